// File: rtl/rv_mc_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: state codes,
// opcode values, datapath mux encodings and the immediate-format decoder.
package rv_mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t S_FETCH    = 4'd0;
    localparam state_t S_DECODE   = 4'd1;
    localparam state_t S_MEMADR   = 4'd2;
    localparam state_t S_MEMREAD  = 4'd3;
    localparam state_t S_MEMWB    = 4'd4;
    localparam state_t S_MEMWRITE = 4'd5;
    localparam state_t S_EXECR    = 4'd6;
    localparam state_t S_EXECI    = 4'd7;
    localparam state_t S_ALUWB    = 4'd8;
    localparam state_t S_BRANCH   = 4'd9;
    localparam state_t S_JAL      = 4'd10;
    localparam state_t S_JALR     = 4'd11;
    localparam state_t S_UPPER    = 4'd12;
    localparam state_t S_HALT     = 4'd13;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Immediate format selected purely by opcode; unknown opcodes fall back to I.
    function automatic logic [2:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:          return IMM_S;
            OP_BRANCH:         return IMM_B;
            OP_JAL:            return IMM_J;
            OP_LUI, OP_AUIPC:  return IMM_U;
            default:           return IMM_I;
        endcase
    endfunction

    // True for every opcode the controller knows how to sequence.
    function automatic logic legal_op(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Memory watchdog: counts consecutive wait cycles of one memory access and
// flags expiry on the wait cycle that brings the count to MEM_TIMEOUT.
module mem_wait_timer
    import rv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic wait_i,
    output logic expired
);

    generate
        if (MEM_TIMEOUT == 0) begin : gen_off
            assign expired = 1'b0;
        end else begin : gen_on
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            logic [CW-1:0] count;

            // Wait-cycle counter, cleared whenever no access is pending or one completes.
            always_ff @(posedge clk) begin
                if (reset || clr)
                    count <= '0;
                else if (wait_i)
                    count <= count + CW'(1);
            end

            assign expired = wait_i && (count == CW'(MEM_TIMEOUT - 1));
        end
    endgenerate

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I main controller: sequences fetch, decode, execute,
// memory and writeback, with memory ready handshake, a wait watchdog and
// a selectable policy for illegal opcodes (sticky halt or skip).
module mc_control_fsm
    import rv_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter bit ILLEGAL_HALT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic       trap,
    output logic       bus_err
);

    state_t state;
    state_t next_state;
    logic   trap_q;
    logic   bus_err_q;
    logic   in_mem;
    logic   wait_now;
    logic   expired;
    logic   illegal;

    assign in_mem   = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    assign wait_now = in_mem && !mem_ready;
    assign illegal  = !legal_op(op);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (!in_mem || mem_ready),
        .wait_i  (wait_now),
        .expired (expired)
    );

    // Next-state selection; a completed access always beats watchdog expiry.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH: begin
                if (mem_ready)    next_state = S_DECODE;
                else if (expired) next_state = S_HALT;
            end
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    OP_JALR:           next_state = S_JALR;
                    OP_LUI, OP_AUIPC:  next_state = S_UPPER;
                    default:           next_state = ILLEGAL_HALT ? S_HALT : S_FETCH;
                endcase
            end
            S_MEMADR:   next_state = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD: begin
                if (mem_ready)    next_state = S_MEMWB;
                else if (expired) next_state = S_HALT;
            end
            S_MEMWB:    next_state = S_FETCH;
            S_MEMWRITE: begin
                if (mem_ready)    next_state = S_FETCH;
                else if (expired) next_state = S_HALT;
            end
            S_EXECR:    next_state = S_ALUWB;
            S_EXECI:    next_state = S_ALUWB;
            S_UPPER:    next_state = S_ALUWB;
            S_ALUWB:    next_state = S_FETCH;
            S_BRANCH:   next_state = S_FETCH;
            S_JALR:     next_state = S_JAL;
            S_JAL:      next_state = S_ALUWB;
            S_HALT:     next_state = S_HALT;
            default:    next_state = S_FETCH;
        endcase
    end

    // State register plus the sticky trap and bus-error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            trap_q    <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state <= next_state;
            if (ILLEGAL_HALT && (state == S_DECODE) && illegal)
                trap_q <= 1'b1;
            if (expired)
                bus_err_q <= 1'b1;
        end
    end

    // Per-state datapath controls; everything is forced low while reset is high.
    always_comb begin
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        alu_op     = ALU_ADD;
        imm_src    = IMM_I;
        trap       = 1'b0;
        bus_err    = 1'b0;
        if (!reset) begin
            trap    = trap_q || ((state == S_DECODE) && illegal);
            bus_err = bus_err_q;
            if (state != S_HALT)
                imm_src = imm_src_of(op);
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMADR, S_JALR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    result_src = RES_DATA;
                    reg_write  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req   = 1'b1;
                    adr_src   = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXECR: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALU_FUNCT;
                end
                S_EXECI: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_FUNCT;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALU_SUB;
                    pc_write  = branch_taken;
                end
                S_JAL: begin
                    alu_src_a = SRCA_OLDPC;
                    alu_src_b = SRCB_FOUR;
                    pc_write  = 1'b1;
                end
                S_UPPER: begin
                    alu_src_a = (op == OP_AUIPC) ? SRCA_OLDPC : SRCA_ZERO;
                    alu_src_b = SRCB_IMM;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed scoreboard bench for mc_control_fsm. Two instances share the
// stimulus: "a" halts on illegal opcodes with a 4-cycle watchdog, "b" skips
// illegal opcodes with the default 16-cycle watchdog.
module tb_mc_control_fsm;

    localparam logic [6:0] OPR    = 7'b0110011;
    localparam logic [6:0] OPLW   = 7'b0000011;
    localparam logic [6:0] OPSW   = 7'b0100011;
    localparam logic [6:0] OPB    = 7'b1100011;
    localparam logic [6:0] OPJAL  = 7'b1101111;
    localparam logic [6:0] OPJALR = 7'b1100111;
    localparam logic [6:0] OPLUI  = 7'b0110111;
    localparam logic [6:0] OPBAD  = 7'b1111111;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic       branch_taken;
    logic       mem_ready;

    logic       a_mem_req, a_adr_src, a_mem_write, a_ir_write, a_pc_write, a_reg_write;
    logic [1:0] a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op;
    logic [2:0] a_imm_src;
    logic       a_trap, a_bus_err;
    logic       b_mem_req, b_adr_src, b_mem_write, b_ir_write, b_pc_write, b_reg_write;
    logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op;
    logic [2:0] b_imm_src;
    logic       b_trap, b_bus_err;

    int vectors = 0;
    int miscompares = 0;

    logic [18:0] qa[$];
    logic [18:0] qb[$];
    string       qt[$];

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    mc_control_fsm #(.MEM_TIMEOUT(4), .ILLEGAL_HALT(1'b1)) dut_a (
        .clk(clk), .reset(reset), .op(op), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(a_mem_req), .adr_src(a_adr_src), .mem_write(a_mem_write), .ir_write(a_ir_write),
        .pc_write(a_pc_write), .reg_write(a_reg_write), .result_src(a_result_src),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .alu_op(a_alu_op),
        .imm_src(a_imm_src), .trap(a_trap), .bus_err(a_bus_err)
    );

    mc_control_fsm #(.MEM_TIMEOUT(16), .ILLEGAL_HALT(1'b0)) dut_b (
        .clk(clk), .reset(reset), .op(op), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(b_mem_req), .adr_src(b_adr_src), .mem_write(b_mem_write), .ir_write(b_ir_write),
        .pc_write(b_pc_write), .reg_write(b_reg_write), .result_src(b_result_src),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .alu_op(b_alu_op),
        .imm_src(b_imm_src), .trap(b_trap), .bus_err(b_bus_err)
    );

    function automatic logic [18:0] pk(input logic mr, input logic adr, input logic mw,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] ao,
                                       input logic [2:0] imm, input logic tr, input logic be);
        return {mr, adr, mw, irw, pcw, rw, rs, a, b, ao, imm, tr, be};
    endfunction

    function automatic logic [2:0] immOf(input logic [6:0] o);
        case (o)
            OPSW:          return 3'b001;
            OPB:           return 3'b010;
            OPJAL:         return 3'b011;
            OPLUI, 7'b0010111: return 3'b100;
            default:       return 3'b000;
        endcase
    endfunction

    function automatic logic [18:0] vFetch(input logic r, input logic [6:0] o);
        return pk(1, 0, 0, r, r, 0, 2'b10, 2'b00, 2'b10, 2'b00, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vDecode(input logic [6:0] o, input logic tr);
        return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, immOf(o), tr, 0);
    endfunction
    function automatic logic [18:0] vMemAdr(input logic [6:0] o);
        return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vMemRead(input logic [6:0] o);
        return pk(1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vMemWb(input logic [6:0] o);
        return pk(0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vMemWrite(input logic [6:0] o);
        return pk(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vExecR(input logic [6:0] o);
        return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vAluWb(input logic [6:0] o);
        return pk(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vBranch(input logic [6:0] o, input logic bt);
        return pk(0, 0, 0, 0, bt, 0, 2'b00, 2'b10, 2'b00, 2'b01, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vJalr(input logic [6:0] o);
        return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vJal(input logic [6:0] o);
        return pk(0, 0, 0, 0, 1, 0, 2'b00, 2'b01, 2'b10, 2'b00, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vUpper(input logic [6:0] o, input logic [1:0] a);
        return pk(0, 0, 0, 0, 0, 0, 2'b00, a, 2'b01, 2'b00, immOf(o), 0, 0);
    endfunction
    function automatic logic [18:0] vHalt(input logic tr, input logic be);
        return pk(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, tr, be);
    endfunction

    // Drive one cycle's inputs and queue what each instance must show for it.
    task automatic applyStimulus(input string tag, input logic rst, input logic [6:0] o,
                                 input logic bt, input logic rdy,
                                 input logic [18:0] ea, input logic [18:0] eb);
        reset        = rst;
        op           = o;
        branch_taken = bt;
        mem_ready    = rdy;
        qa.push_back(ea);
        qb.push_back(eb);
        qt.push_back(tag);
    endtask

    // Sample mid low phase, compare against the queue head, then move to the next cycle.
    task automatic checkOutput();
        logic [18:0] ea, eb, oa, ob;
        string tag;
        #2;
        ea  = qa.pop_front();
        eb  = qb.pop_front();
        tag = qt.pop_front();
        oa = {a_mem_req, a_adr_src, a_mem_write, a_ir_write, a_pc_write, a_reg_write,
              a_result_src, a_alu_src_a, a_alu_src_b, a_alu_op, a_imm_src, a_trap, a_bus_err};
        ob = {b_mem_req, b_adr_src, b_mem_write, b_ir_write, b_pc_write, b_reg_write,
              b_result_src, b_alu_src_a, b_alu_src_b, b_alu_op, b_imm_src, b_trap, b_bus_err};
        vectors++;
        assert (oa === ea) else begin
            miscompares++;
            $error("[TB] FAIL %s/a observed=%h expected=%h", tag, oa, ea);
        end
        vectors++;
        assert (ob === eb) else begin
            miscompares++;
            $error("[TB] FAIL %s/b observed=%h expected=%h", tag, ob, eb);
        end
        @(negedge clk);
    endtask

    task automatic run(input string tag, input logic rst, input logic [6:0] o,
                       input logic bt, input logic rdy,
                       input logic [18:0] ea, input logic [18:0] eb);
        applyStimulus(tag, rst, o, bt, rdy, ea, eb);
        checkOutput();
    endtask

    initial begin
        run("rst0", 1, OPR, 0, 1, '0, '0);
        run("rst1", 1, OPR, 0, 1, '0, '0);

        run("add_f",  0, OPR, 0, 1, vFetch(1, OPR), vFetch(1, OPR));
        run("add_d",  0, OPR, 0, 1, vDecode(OPR, 0), vDecode(OPR, 0));
        run("add_x",  0, OPR, 0, 1, vExecR(OPR), vExecR(OPR));
        run("add_wb", 0, OPR, 0, 1, vAluWb(OPR), vAluWb(OPR));

        run("lw_f",   0, OPLW, 0, 1, vFetch(1, OPLW), vFetch(1, OPLW));
        run("lw_d",   0, OPLW, 0, 0, vDecode(OPLW, 0), vDecode(OPLW, 0));
        run("lw_ma",  0, OPLW, 0, 0, vMemAdr(OPLW), vMemAdr(OPLW));
        run("lw_w0",  0, OPLW, 0, 0, vMemRead(OPLW), vMemRead(OPLW));
        run("lw_w1",  0, OPLW, 0, 0, vMemRead(OPLW), vMemRead(OPLW));
        run("lw_w2",  0, OPLW, 0, 0, vMemRead(OPLW), vMemRead(OPLW));
        run("lw_rd",  0, OPLW, 0, 1, vMemRead(OPLW), vMemRead(OPLW));
        run("lw_wb",  0, OPLW, 0, 0, vMemWb(OPLW), vMemWb(OPLW));

        run("bnt_f",  0, OPB, 0, 1, vFetch(1, OPB), vFetch(1, OPB));
        run("bnt_d",  0, OPB, 0, 1, vDecode(OPB, 0), vDecode(OPB, 0));
        run("bnt_br", 0, OPB, 0, 1, vBranch(OPB, 0), vBranch(OPB, 0));
        run("bt_f",   0, OPB, 1, 1, vFetch(1, OPB), vFetch(1, OPB));
        run("bt_d",   0, OPB, 1, 1, vDecode(OPB, 0), vDecode(OPB, 0));
        run("bt_br",  0, OPB, 1, 1, vBranch(OPB, 1), vBranch(OPB, 1));

        run("jalr_f",  0, OPJALR, 0, 1, vFetch(1, OPJALR), vFetch(1, OPJALR));
        run("jalr_d",  0, OPJALR, 0, 1, vDecode(OPJALR, 0), vDecode(OPJALR, 0));
        run("jalr_x",  0, OPJALR, 0, 1, vJalr(OPJALR), vJalr(OPJALR));
        run("jalr_j",  0, OPJALR, 0, 1, vJal(OPJALR), vJal(OPJALR));
        run("jalr_wb", 0, OPJALR, 0, 1, vAluWb(OPJALR), vAluWb(OPJALR));

        run("sw_f",  0, OPSW, 0, 1, vFetch(1, OPSW), vFetch(1, OPSW));
        run("sw_d",  0, OPSW, 0, 1, vDecode(OPSW, 0), vDecode(OPSW, 0));
        run("sw_ma", 0, OPSW, 0, 1, vMemAdr(OPSW), vMemAdr(OPSW));
        run("sw_mw", 0, OPSW, 0, 1, vMemWrite(OPSW), vMemWrite(OPSW));

        run("lui_f",  0, OPLUI, 0, 1, vFetch(1, OPLUI), vFetch(1, OPLUI));
        run("lui_d",  0, OPLUI, 0, 1, vDecode(OPLUI, 0), vDecode(OPLUI, 0));
        run("lui_u",  0, OPLUI, 0, 1, vUpper(OPLUI, 2'b11), vUpper(OPLUI, 2'b11));
        run("lui_wb", 0, OPLUI, 0, 1, vAluWb(OPLUI), vAluWb(OPLUI));

        run("jal_f",  0, OPJAL, 0, 1, vFetch(1, OPJAL), vFetch(1, OPJAL));
        run("jal_d",  0, OPJAL, 0, 1, vDecode(OPJAL, 0), vDecode(OPJAL, 0));
        run("jal_j",  0, OPJAL, 0, 1, vJal(OPJAL), vJal(OPJAL));
        run("jal_wb", 0, OPJAL, 0, 1, vAluWb(OPJAL), vAluWb(OPJAL));

        run("ill_f",  0, OPBAD, 0, 1, vFetch(1, OPBAD), vFetch(1, OPBAD));
        run("ill_d",  0, OPBAD, 0, 1, vDecode(OPBAD, 1), vDecode(OPBAD, 1));
        run("ill_1",  0, OPR, 0, 1, vHalt(1, 0), vFetch(1, OPR));
        run("ill_2",  0, OPR, 0, 1, vHalt(1, 0), vDecode(OPR, 0));
        run("ill_3",  0, OPR, 0, 1, vHalt(1, 0), vExecR(OPR));
        run("ill_rst", 1, OPR, 0, 1, '0, '0);

        run("to_w0", 0, OPR, 0, 0, vFetch(0, OPR), vFetch(0, OPR));
        run("to_w1", 0, OPR, 0, 0, vFetch(0, OPR), vFetch(0, OPR));
        run("to_w2", 0, OPR, 0, 0, vFetch(0, OPR), vFetch(0, OPR));
        run("to_w3", 0, OPR, 0, 0, vFetch(0, OPR), vFetch(0, OPR));
        run("to_h0", 0, OPR, 0, 0, vHalt(0, 1), vFetch(0, OPR));
        run("to_h1", 0, OPR, 0, 1, vHalt(0, 1), vFetch(1, OPR));
        run("to_rst", 1, OPR, 0, 1, '0, '0);
        run("to_f",  0, OPR, 0, 1, vFetch(1, OPR), vFetch(1, OPR));
        run("to_d",  0, OPR, 0, 1, vDecode(OPR, 0), vDecode(OPR, 0));
        run("to_x",  0, OPR, 0, 1, vExecR(OPR), vExecR(OPR));
        run("to_wb", 0, OPR, 0, 1, vAluWb(OPR), vAluWb(OPR));

        run("ab_f",   0, OPSW, 0, 1, vFetch(1, OPSW), vFetch(1, OPSW));
        run("ab_d",   0, OPSW, 0, 1, vDecode(OPSW, 0), vDecode(OPSW, 0));
        run("ab_ma",  0, OPSW, 0, 0, vMemAdr(OPSW), vMemAdr(OPSW));
        run("ab_mw",  0, OPSW, 0, 0, vMemWrite(OPSW), vMemWrite(OPSW));
        run("ab_rst", 1, OPSW, 0, 0, '0, '0);
        run("ab_f2",  0, OPSW, 0, 1, vFetch(1, OPSW), vFetch(1, OPSW));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
# mc_control_fsm

Multi-cycle RV32I main controller: generalises the single-cycle opcode decoder into a state machine that sequences fetch, decode, execute, memory and writeback over several cycles. It adds a ready-handshake to a shared instruction/data memory, a parametrised memory-timeout watchdog, and a configurable illegal-opcode policy. It sits between the instruction register and the multi-cycle datapath (PC, OldPC, IR, ALUOut, Data registers).

## Interface
- MEM_TIMEOUT, 16, max wait cycles per memory access before bus error; 0 disables the watchdog.
- ILLEGAL_HALT, 1, 1: illegal opcode halts (sticky); 0: illegal opcode is skipped as a NOP.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  7  IR[6:0].
- branch_taken  in  1  branch-condition result from the comparator, valid in S_BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- adr_src  out  1  0 = PC, 1 = ALUOut.
- mem_write  out  1  store strobe.
- ir_write  out  1  load IR and OldPC.
- pc_write  out  1  load PC from Result.
- reg_write  out  1  register-file write.
- result_src  out  2  00 ALUOut, 01 Data, 10 ALU result.
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1, 11 zero.
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4.
- alu_op  out  2  00 add, 01 branch/sub, 10 funct-decoded.
- imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U; 000 for unlisted opcodes.
- trap  out  1  illegal opcode detected.
- bus_err  out  1  memory watchdog expired.

## Operation
- Outputs not listed for a state are 0. imm_src is a combinational function of op only.
- S_FETCH: mem_req, adr_src=0, a=00, b=10, alu_op=00, result_src=10. ir_write and pc_write are asserted only in the cycle mem_ready=1, which also advances to S_DECODE; otherwise the FSM holds.
- S_DECODE: a=01, b=01, alu_op=00, so ALUOut = OldPC+imm. Next state by op: lw/sw→S_MEMADR, R→S_EXECR, I-ALU→S_EXECI, B→S_BRANCH, jal→S_JAL, jalr→S_JALR, lui/auipc→S_UPPER, other→illegal handling.
- S_MEMADR: a=10, b=01, alu_op=00. Next is S_MEMREAD for lw, S_MEMWRITE for sw.
- S_MEMREAD: mem_req, adr_src=1. On mem_ready go to S_MEMWB. S_MEMWB: result_src=01, reg_write, then S_FETCH.
- S_MEMWRITE: mem_req, adr_src=1, mem_write. Hold until mem_ready, then S_FETCH.
- S_EXECR: a=10, b=00, alu_op=10. S_EXECI: a=10, b=01, alu_op=10. Both go to S_ALUWB.
- S_ALUWB: result_src=00, reg_write, then S_FETCH.
- S_BRANCH: a=10, b=00, alu_op=01, result_src=00, pc_write=branch_taken, then S_FETCH.
- S_JALR: a=10, b=01, alu_op=00 (ALUOut = rs1+imm), then S_JAL.
- S_JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1, then S_ALUWB, which writes OldPC+4.
- S_UPPER: a=01 for auipc, 11 for lui; b=01, alu_op=00, then S_ALUWB.
- Illegal opcode with ILLEGAL_HALT=1: go to S_HALT. trap is held high until reset; all other outputs are 0.
- Illegal opcode with ILLEGAL_HALT=0: trap pulses for one cycle (the S_DECODE cycle), then S_FETCH with no state change.
- Watchdog: the counter clears on entry to any mem_req state and increments each cycle mem_ready=0. When it reaches MEM_TIMEOUT, go to S_HALT with bus_err sticky. mem_ready in the same cycle wins.

## Timing
- Moore outputs, except ir_write, pc_write (S_FETCH, gated by mem_ready) and pc_write in S_BRANCH (gated by branch_taken).
- Cycles per instruction with zero wait states: branch 3; R, I, sw, jal, lui, auipc 4; lw, jalr 5. Each wait cycle adds 1.
- While reset=1, all outputs are forced to 0. The reset edge sets state=S_FETCH, clears the counter, trap and bus_err. The first fetch request appears in the cycle after reset deasserts.
- Reset mid-access aborts the access. No mem_write is asserted in the reset cycle.
- Watchdog counter width is $clog2(MEM_TIMEOUT+1).

## Structure
- Shared package rv_mc_pkg holds: state_t enum; opcode localparams; result_src, alu_src_a and alu_src_b encodings; imm_src function.
- Sub-module mem_wait_timer (parameter MEM_TIMEOUT; inputs clr, wait_i; output expired) contains the watchdog.

## Test plan
- add (op=0110011), mem_ready tied to 1 → states F,D,EXECR,ALUWB; reg_write only in cycle 4; ir_write=pc_write=1 in cycle 1.
- lw with mem_ready low for 3 cycles in S_MEMREAD → mem_req/adr_src=1 held for 4 cycles; reg_write with result_src=01 one cycle after ready; 8 cycles total.
- beq with branch_taken=0, then =1 → pc_write=0, then 1, in the S_BRANCH cycle; 3 cycles each.
- jalr → S_JALR (a=10, b=01) → S_JAL with pc_write=1 → S_ALUWB with reg_write=1.
- op=1111111: with ILLEGAL_HALT=1, trap stays 1 and outputs stay 0 until reset; with ILLEGAL_HALT=0, a one-cycle trap pulse and the next fetch follows.
- MEM_TIMEOUT=4 with mem_ready held 0 in S_FETCH → bus_err=1 after 4 wait cycles, FSM in S_HALT; reset returns to S_FETCH with bus_err=0.
